// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - multi-channel programmable interval timer with shared prescaler
// Channels count on the shared TICK; a bus write to CTRL/PRESET pre-empts only the addressed channel.
module multi_timer #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              CLK_I,
    input  logic              RST_N_I,
    input  logic [ADDR_W+1:0] ADD_I,
    input  logic              WE_I,
    input  logic [31:0]       DAT_I,
    output logic [31:0]       DAT_O,
    output logic [NUM_CH-1:0] TOUT_O,
    output logic [NUM_CH-1:0] IRQ_VEC_O,
    output logic              IRQ
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_LOAD   = 4'b0010,
        ST_CNTING = 4'b0100,
        ST_EXPIRE = 4'b1000
    } ch_state_t;

    localparam logic [ADDR_W-1:0] PRESC_WORD = '1;

    logic [ADDR_W-1:0] word;
    logic              unused_bits;

    assign word        = ADD_I[ADDR_W+1:2];
    assign unused_bits = ^{ADD_I[1:0], DAT_I};

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_cnt_q;
    logic               presc_wr;
    logic               tick;

    assign presc_wr = WE_I && (word == PRESC_WORD);
    assign tick     = (presc_cnt_q == presc_q) && !presc_wr;

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            presc_q     <= '0;
            presc_cnt_q <= '0;
        end else if (presc_wr) begin
            presc_q     <= DAT_I[PRESC_W-1:0];
            presc_cnt_q <= '0;
        end else if (presc_cnt_q == presc_q) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
        end
    end

    logic [3:0]       ctrl_v   [NUM_CH];
    logic [CNT_W-1:0] preset_v [NUM_CH];
    logic [CNT_W-1:0] count_v  [NUM_CH];
    logic [NUM_CH-1:0] pend_v;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [ADDR_W-3:0] CH_IDX = (ADDR_W-2)'(c);

        ch_state_t        state_q, state_d;
        logic [3:0]       ctrl_q, ctrl_d;
        logic [CNT_W-1:0] preset_q, preset_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic             pend_q, pend_d;
        logic             tout_q, tout_d;
        logic             sel, wr_ctrl, wr_preset, wr_status;
        logic             en, periodic, expire_hit;

        assign sel       = (word[ADDR_W-1:2] == CH_IDX);
        assign wr_ctrl   = WE_I && sel && (word[1:0] == 2'd0);
        assign wr_preset = WE_I && sel && (word[1:0] == 2'd1);
        assign wr_status = WE_I && sel && (word[1:0] == 2'd3);
        assign en        = ctrl_q[0];
        // Mode 11 behaves as one-shot, so only 01 and 10 reload.
        assign periodic  = (ctrl_q[2:1] == 2'b01) || (ctrl_q[2:1] == 2'b10);

        always_ff @(posedge CLK_I or negedge RST_N_I) begin
            if (!RST_N_I) begin
                state_q  <= ST_IDLE;
                ctrl_q   <= '0;
                preset_q <= '0;
                count_q  <= '0;
                pend_q   <= 1'b0;
                tout_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                ctrl_q   <= ctrl_d;
                preset_q <= preset_d;
                count_q  <= count_d;
                pend_q   <= pend_d;
                tout_q   <= tout_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            ctrl_d     = ctrl_q;
            preset_d   = preset_q;
            count_d    = count_q;
            tout_d     = tout_q;
            expire_hit = 1'b0;

            if (wr_ctrl) begin
                ctrl_d  = DAT_I[3:0];
                state_d = ST_IDLE;
            end else if (wr_preset) begin
                preset_d = DAT_I[CNT_W-1:0];
                state_d  = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (en) state_d = ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (en) begin
                            count_d = preset_q;
                            if (preset_q == '0) expire_hit = 1'b1;
                            else                state_d    = ST_CNTING;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_CNTING: begin
                        if (!en) begin
                            state_d = ST_IDLE;
                        end else if (tick) begin
                            count_d = count_q - CNT_W'(1);
                            if (count_q == CNT_W'(1)) expire_hit = 1'b1;
                        end
                    end
                    ST_EXPIRE: begin
                        if (periodic) begin
                            count_d = preset_q;
                            if (preset_q == '0) expire_hit = 1'b1;
                            else                state_d    = ST_CNTING;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            if (expire_hit) begin
                state_d = ST_EXPIRE;
                if (!periodic) ctrl_d[0] = 1'b0;
                if (ctrl_q[2:1] == 2'b10) tout_d = ~tout_q;
            end

            // An expiry in the same cycle as a W1C keeps the pending bit set.
            pend_d = expire_hit | (pend_q & ~(wr_status & DAT_I[0]));
        end

        assign TOUT_O[c]    = tout_q;
        assign IRQ_VEC_O[c] = pend_q & ctrl_q[3];
        assign ctrl_v[c]    = ctrl_q;
        assign preset_v[c]  = preset_q;
        assign count_v[c]   = count_q;
        assign pend_v[c]    = pend_q;
    end

    assign IRQ = |IRQ_VEC_O;

    always_comb begin
        DAT_O = 32'h8000_0000;
        if (word == PRESC_WORD) begin
            DAT_O                = '0;
            DAT_O[PRESC_W-1:0]   = presc_q;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (word[ADDR_W-1:2] == (ADDR_W-2)'(c)) begin
                DAT_O = '0;
                case (word[1:0])
                    2'd0:    DAT_O[3:0]       = ctrl_v[c];
                    2'd1:    DAT_O[CNT_W-1:0] = preset_v[c];
                    2'd2:    DAT_O[CNT_W-1:0] = count_v[c];
                    default: DAT_O[0]         = pend_v[c];
                endcase
            end
        end
    end

endmodule
